// File: rtl/uart_cmd_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_wrapper_if
// Description : Command/response handshake between the UART front end and
//               cmd_cfg. The master side is the UART wrapper. The slave side
//               is the command consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_wrapper_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        snd_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    modport master (
        output cmd,
        output data,
        output cmd_rdy,
        output resp_sent,
        input  clr_cmd_rdy,
        input  snd_resp,
        input  resp
    );

    modport slave (
        input  cmd,
        input  data,
        input  cmd_rdy,
        input  resp_sent,
        output clr_cmd_rdy,
        output snd_resp,
        output resp
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_wrapper
// Description : Wireless-link front end. An 8N1 UART receiver collects 3-byte
//               frames of the form {cmd, data_hi, data_lo} and presents them
//               with a cmd_rdy/clr_cmd_rdy handshake. An 8N1 transmitter
//               serialises one response byte per snd_resp pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            RX,
    output logic                 TX,
    uart_cmd_wrapper_if.master   bus
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'((BAUD_DIV / 2) - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    logic        rx_ff1, rx_sync, rx_hist;
    logic        rx_fall;
    rx_state_t   rx_state, rx_nxt;
    logic [11:0] rx_cnt;
    logic [3:0]  rx_bit_cnt;
    logic [7:0]  rx_shift;
    logic        rx_cnt_clr, rx_shift_en, byte_ok, frame_err, new_byte;
    logic [1:0]  byte_idx;
    logic [7:0]  cmd_q;
    logic [15:0] data_q;
    logic        cmd_rdy_q;

    // RX is asynchronous: two flops for metastability, one for edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_sync <= 1'b1;
            rx_hist <= 1'b1;
        end else begin
            rx_ff1  <= RX;
            rx_sync <= rx_ff1;
            rx_hist <= rx_sync;
        end
    end

    assign rx_fall = rx_hist & ~rx_sync;

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_nxt;
    end

    // RX next-state and per-cycle control strobes.
    always_comb begin
        rx_nxt      = rx_state;
        rx_cnt_clr  = 1'b0;
        rx_shift_en = 1'b0;
        byte_ok     = 1'b0;
        frame_err   = 1'b0;
        new_byte    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_nxt     = RX_START;
                    rx_cnt_clr = 1'b1;
                end
            end
            RX_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_clr = 1'b1;
                    if (!rx_sync) begin
                        rx_nxt   = RX_DATA;
                        new_byte = 1'b1;
                    end else begin
                        rx_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == BAUD_LAST) begin
                    rx_cnt_clr  = 1'b1;
                    rx_shift_en = 1'b1;
                    if (rx_bit_cnt == 4'd7) rx_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BAUD_LAST) begin
                    rx_cnt_clr = 1'b1;
                    rx_nxt     = RX_IDLE;
                    if (rx_sync) byte_ok   = 1'b1;
                    else         frame_err = 1'b1;
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // RX baud/bit counters and the LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt     <= 12'd0;
            rx_bit_cnt <= 4'd0;
            rx_shift   <= 8'h00;
        end else begin
            rx_cnt <= rx_cnt_clr ? 12'd0 : rx_cnt + 12'd1;
            if (new_byte)
                rx_bit_cnt <= 4'd0;
            else if (rx_shift_en)
                rx_bit_cnt <= rx_bit_cnt + 4'd1;
            if (rx_shift_en)
                rx_shift <= {rx_sync, rx_shift[7:1]};
        end
    end

    // Frame assembly: route each valid byte by index. A framing error resyncs the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            cmd_q    <= 8'h00;
            data_q   <= 16'h0000;
        end else if (frame_err) begin
            byte_idx <= 2'd0;
        end else if (byte_ok) begin
            case (byte_idx)
                2'd0: begin
                    cmd_q    <= rx_shift;
                    byte_idx <= 2'd1;
                end
                2'd1: begin
                    data_q[15:8] <= rx_shift;
                    byte_idx     <= 2'd2;
                end
                default: begin
                    data_q[7:0] <= rx_shift;
                    byte_idx    <= 2'd0;
                end
            endcase
        end
    end

    // cmd_rdy: set on the last byte of a frame (set wins), cleared by consumer or a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmd_rdy_q <= 1'b0;
        else if (byte_ok && (byte_idx == 2'd2))
            cmd_rdy_q <= 1'b1;
        else if (bus.clr_cmd_rdy || new_byte)
            cmd_rdy_q <= 1'b0;
    end

    assign bus.cmd     = cmd_q;
    assign bus.data    = data_q;
    assign bus.cmd_rdy = cmd_rdy_q;

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    tx_state_t   tx_state, tx_nxt;
    logic [11:0] tx_cnt;
    logic [3:0]  tx_bit_cnt;
    logic [8:0]  tx_shift;
    logic        tx_line;
    logic        tx_load, tx_bit_adv, tx_done;
    logic        resp_sent_q;

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_nxt;
    end

    // TX next-state; snd_resp is only honoured in IDLE.
    always_comb begin
        tx_nxt     = tx_state;
        tx_load    = 1'b0;
        tx_bit_adv = 1'b0;
        tx_done    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (bus.snd_resp) begin
                    tx_nxt  = TX_SEND;
                    tx_load = 1'b1;
                end
            end
            TX_SEND: begin
                if (tx_cnt == BAUD_LAST) begin
                    tx_bit_adv = 1'b1;
                    if (tx_bit_cnt == 4'd9) begin
                        tx_done = 1'b1;
                        tx_nxt  = TX_IDLE;
                    end
                end
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    // TX datapath: the start bit goes out directly from the load; the shifter holds data+stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt      <= 12'd0;
            tx_bit_cnt  <= 4'd0;
            tx_shift    <= 9'h1FF;
            tx_line     <= 1'b1;
            resp_sent_q <= 1'b0;
        end else if (tx_load) begin
            tx_cnt      <= 12'd0;
            tx_bit_cnt  <= 4'd0;
            tx_shift    <= {1'b1, bus.resp};
            tx_line     <= 1'b0;
            resp_sent_q <= 1'b0;
        end else if (tx_done) begin
            tx_line     <= 1'b1;
            resp_sent_q <= 1'b1;
        end else if (tx_bit_adv) begin
            tx_cnt     <= 12'd0;
            tx_bit_cnt <= tx_bit_cnt + 4'd1;
            tx_line    <= tx_shift[0];
            tx_shift   <= {1'b1, tx_shift[8:1]};
        end else if (tx_state == TX_SEND) begin
            tx_cnt <= tx_cnt + 12'd1;
        end
    end

    assign TX            = tx_line;
    assign bus.resp_sent = resp_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_wrapper
// Description : Self-checking bench for uart_cmd_wrapper. Expected frames are
//               queued when driven on RX and compared when cmd_rdy rises. The
//               TX waveform is compared against a locally built bit pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_wrapper;

    localparam int BAUD = 16;

    logic clk;
    logic rst_n;
    logic RX;
    logic TX;

    uart_cmd_wrapper_if bus();

    uart_cmd_wrapper #(.BAUD_DIV(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rises   = 0;
    logic [23:0] sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = stop_bit;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
        sb_q.push_back({c, d});
        send_byte(c, 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_val("sb_drain", sb_q.size(), 0);
    endtask

    task automatic glitch(input int len);
        @(negedge clk);
        RX = 1'b0;
        repeat (len) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
    endtask

    // Scoreboard monitor: each cmd_rdy rise pops one expected frame.
    initial begin
        logic        prev;
        logic [23:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cmd_rdy && !prev) begin
                rises++;
                if (sb_q.size() == 0) begin
                    check_val("unexpected_rdy", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("cmd", bus.cmd, e[23:16]);
                    check_val("data", bus.data, e[15:0]);
                end
            end
            prev = bus.cmd_rdy;
        end
    end

    initial begin
        int          r0;
        int          bad[10];
        logic [9:0]  txf;

        RX              = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        bus.snd_resp    = 1'b0;
        bus.resp        = 8'h00;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx", TX, 1);
        check_val("rst_cmd", bus.cmd, 8'h00);
        check_val("rst_data", bus.data, 16'h0000);
        check_val("rst_rdy", bus.cmd_rdy, 0);
        check_val("rst_sent", bus.resp_sent, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame, single rise.
        r0 = rises;
        send_frame(8'h05, 16'h1234);
        wait_drain();
        repeat (40) @(negedge clk);
        check_val("rise_once", rises - r0, 1);

        // Consumer clear keeps the held frame.
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        check_val("clr_rdy", bus.cmd_rdy, 0);
        check_val("clr_cmd_hold", bus.cmd, 8'h05);
        check_val("clr_data_hold", bus.data, 16'h1234);

        // Framing error resynchronises the frame.
        send_byte(8'h02, 1'b1);
        send_byte(8'hFF, 1'b0);
        check_val("ferr_no_rdy", bus.cmd_rdy, 0);
        check_val("ferr_cmd_first", bus.cmd, 8'h02);
        send_frame(8'h06, 16'hABCD);
        wait_drain();

        // Glitch neither clears cmd_rdy nor moves the byte index.
        glitch(5);
        check_val("glitch_rdy_kept", bus.cmd_rdy, 1);
        check_val("glitch_cmd_kept", bus.cmd, 8'h06);
        sb_q.push_back({8'h77, 16'h8899});
        send_byte(8'h77, 1'b1);
        check_val("newbyte_clr", bus.cmd_rdy, 0);
        glitch(5);
        send_byte(8'h88, 1'b1);
        send_byte(8'h99, 1'b1);
        wait_drain();

        // Response transmission with a second snd_resp mid-frame.
        txf = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) bad[i] = 0;
        @(negedge clk);
        bus.resp     = 8'hA5;
        bus.snd_resp = 1'b1;
        for (int k = 1; k <= 161; k++) begin
            @(negedge clk);
            if (k == 1) bus.snd_resp = 1'b0;
            if (k == 70) begin
                bus.snd_resp = 1'b1;
                bus.resp     = 8'h00;
            end
            if (k == 71) bus.snd_resp = 1'b0;
            if (k <= 160 && TX !== txf[(k - 1) / BAUD]) bad[(k - 1) / BAUD]++;
            if (k == 160) check_val("sent_not_early", bus.resp_sent, 0);
            if (k == 161) begin
                check_val("sent_at_161", bus.resp_sent, 1);
                check_val("tx_idle_after", TX, 1);
            end
        end
        for (int i = 0; i < 10; i++) check_val($sformatf("tx_bit%0d_bad", i), bad[i], 0);
        repeat (20) @(negedge clk);
        check_val("tx_stays_idle", TX, 1);
        check_val("sent_held", bus.resp_sent, 1);

        // Reset mid-TX and mid-RX byte 2.
        send_byte(8'h5A, 1'b1);
        check_val("pre_rst_cmd", bus.cmd, 8'h5A);
        @(negedge clk);
        bus.resp     = 8'h3C;
        bus.snd_resp = 1'b1;
        @(negedge clk);
        bus.snd_resp = 1'b0;
        check_val("sent_cleared", bus.resp_sent, 0);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (BAUD + 8) @(negedge clk);
        check_val("pre_rst_tx_low", TX, 0);
        RX    = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mrst_tx", TX, 1);
        check_val("mrst_cmd", bus.cmd, 8'h00);
        check_val("mrst_data", bus.data, 16'h0000);
        check_val("mrst_rdy", bus.cmd_rdy, 0);
        check_val("mrst_sent", bus.resp_sent, 0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h11, 16'h2233);
        wait_drain();
        check_val("post_rst_tx", TX, 1);
        check_val("post_rst_sent", bus.resp_sent, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
